// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 capture front-end: pixel modes, frame FSM states, output-width helper.
package ov7670_pkg;

   typedef enum logic [1:0] {
      MODE_Y      = 2'd0,
      MODE_RGB565 = 2'd1,
      MODE_YAVG2  = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   // Reserved encoding 3 falls back to Y-only.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_RGB565;
         2'd2:    return MODE_YAVG2;
         default: return MODE_Y;
      endcase
   endfunction

   function automatic logic [15:0] out_width(input mode_e m, input logic [15:0] img_w);
      return (m == MODE_YAVG2) ? (img_w >> 1) : img_w;
   endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera byte stream in, frame-memory write strobe and frame status out.
interface ov7670_capture_if #(
   parameter int XW = 10,
   parameter int YW = 10,
   parameter int AW = 19
);
   logic          vsync;
   logic          href;
   logic [7:0]    data;
   logic [1:0]    mode;
   logic [15:0]   value;
   logic [XW-1:0] x_addr;
   logic [YW-1:0] y_addr;
   logic [AW-1:0] mem_addr;
   logic          is_val;
   logic          frame_done;
   logic          frame_err;
   logic [7:0]    frame_cnt;

   modport master (
      output vsync, href, data, mode,
      input  value, x_addr, y_addr, mem_addr, is_val, frame_done, frame_err, frame_cnt
   );

   modport slave (
      input  vsync, href, data, mode,
      output value, x_addr, y_addr, mem_addr, is_val, frame_done, frame_err, frame_cnt
   );
endinterface

// File: rtl/ov7670_pixel_assembler.sv
// Turns the camera byte stream into pixels for the latched mode; pix_valid marks the completing byte.
module ov7670_pixel_assembler
   import ov7670_pkg::*;
(
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic        byte_en,
   input  logic        line_start,
   input  mode_e       cur_mode,
   input  logic [7:0]  data,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic        phase_nz
);

   logic [1:0] phase, ph, phase_nx;
   logic [7:0] hold;
   logic [8:0] sum9;
   logic       capture;

   always_comb begin
      ph        = line_start ? 2'd0 : phase;
      phase_nx  = phase;
      capture   = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      sum9      = {1'b0, hold} + {1'b0, data};
      if (byte_en) begin
         case (cur_mode)
            MODE_YAVG2: begin
               // C Ya C Yb: Ya held on phase 1, rounded average on phase 3
               phase_nx = ph + 2'd1;
               capture  = (ph == 2'd1);
               if (ph == 2'd3) begin
                  pix_valid = 1'b1;
                  pix_data  = {8'h00, 8'((sum9 + 9'd1) >> 1)};
               end
            end
            MODE_RGB565: begin
               phase_nx = {1'b0, ~ph[0]};
               capture  = ~ph[0];
               if (ph[0]) begin
                  pix_valid = 1'b1;
                  pix_data  = {hold, data};
               end
            end
            default: begin
               phase_nx = {1'b0, ~ph[0]};
               if (ph[0]) begin
                  pix_valid = 1'b1;
                  pix_data  = {8'h00, data};
               end
            end
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
         hold  <= '0;
      end else begin
         if (frame_start) phase <= '0;
         else             phase <= phase_nx;
         if (capture) hold <= data;
      end
   end

   assign phase_nz = |phase;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture front-end: frame FSM, address counters and frame bookkeeping around the pixel assembler.
//  state  | meaning
//  SYNC   | after reset, waiting for first vsync high so the first frame is whole
//  VBLANK | vertical blanking, href ignored, waiting for vsync fall
//  ACTIVE | frame in progress, lines captured
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int XW    = 10,
   parameter int YW    = 10,
   parameter int AW    = 19
) (
   input  logic             pclk,
   input  logic             reset_n,
   ov7670_capture_if.slave  bus
);

   localparam logic [YW-1:0] IMG_H_Y = YW'(IMG_H);

   state_e        state, state_nx;
   mode_e         cur_mode;
   logic          vsync_q, line_open, err_sticky;
   logic          frame_start, frame_end, line_end, byte_en, line_start;
   logic          pix_valid, phase_nz, in_frame, emit_ok, over_err, line_err;
   logic [15:0]   pix_data, ow16;
   logic [AW-1:0] out_w_a, row_base;
   logic [XW:0]   out_w_x, cnt_eff;
   logic [YW-1:0] lines_nx;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) state <= SYNC;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         SYNC:    if (bus.vsync) state_nx = VBLANK;
         VBLANK:  if (vsync_q && !bus.vsync) begin
                     state_nx    = ACTIVE;
                     frame_start = 1'b1;
                  end
         ACTIVE:  if (!vsync_q && bus.vsync) begin
                     state_nx  = VBLANK;
                     frame_end = 1'b1;
                  end
         default: state_nx = SYNC;
      endcase
   end

   // A vsync rise closes any open line in the same cycle; that cycle's byte is not captured.
   assign line_end   = (state == ACTIVE) && line_open && (!bus.href || frame_end);
   assign byte_en    = (state == ACTIVE) && bus.href && !frame_end;
   assign line_start = byte_en && !line_open;

   assign ow16     = out_width(cur_mode, 16'(IMG_W));
   assign out_w_a  = AW'(ow16);
   assign out_w_x  = (XW+1)'(ow16);
   // Pixel count includes the strobe currently on the bus, whose x increment lands next cycle.
   assign cnt_eff  = {1'b0, bus.x_addr} + {{XW{1'b0}}, bus.is_val};
   assign in_frame = bus.y_addr < IMG_H_Y;
   assign emit_ok  = pix_valid && (cnt_eff < out_w_x) && in_frame;
   assign over_err = pix_valid && !emit_ok;
   assign line_err = line_end && ((cnt_eff != out_w_x) || phase_nz || !in_frame);
   assign lines_nx = (line_end && in_frame) ? bus.y_addr + 1'b1 : bus.y_addr;

   ov7670_pixel_assembler u_asm (
      .pclk        (pclk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .byte_en     (byte_en),
      .line_start  (line_start),
      .cur_mode    (cur_mode),
      .data        (bus.data),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .phase_nz    (phase_nz)
   );

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q        <= 1'b0;
         line_open      <= 1'b0;
         err_sticky     <= 1'b0;
         cur_mode       <= MODE_Y;
         row_base       <= '0;
         bus.value      <= '0;
         bus.x_addr     <= '0;
         bus.y_addr     <= '0;
         bus.mem_addr   <= '0;
         bus.is_val     <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.frame_cnt  <= '0;
      end else begin
         vsync_q        <= bus.vsync;
         bus.is_val     <= emit_ok;
         bus.value      <= emit_ok ? pix_data : 16'h0000;
         bus.frame_done <= frame_end;
         bus.frame_err  <= frame_end &&
                           (err_sticky || over_err || line_err || (lines_nx != IMG_H_Y));
         if (frame_end) bus.frame_cnt <= bus.frame_cnt + 8'd1;
         if (frame_start) begin
            cur_mode     <= decode_mode(bus.mode);
            line_open    <= 1'b0;
            err_sticky   <= 1'b0;
            row_base     <= '0;
            bus.x_addr   <= '0;
            bus.y_addr   <= '0;
            bus.mem_addr <= '0;
         end else begin
            if (over_err || line_err) err_sticky <= 1'b1;
            if (byte_en) line_open <= 1'b1;
            if (line_end) begin
               line_open  <= 1'b0;
               bus.x_addr <= '0;
               if (in_frame) begin
                  bus.y_addr   <= bus.y_addr + 1'b1;
                  row_base     <= row_base + out_w_a;
                  bus.mem_addr <= row_base + out_w_a;
               end
            end else if (bus.is_val) begin
               bus.x_addr   <= bus.x_addr + 1'b1;
               bus.mem_addr <= bus.mem_addr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomised bench for ov7670_capture: byte-level camera driver plus a per-line pixel/frame reference model.
module tb_ov7670_capture;

   localparam int W  = 32;
   localparam int H  = 8;
   localparam int XW = 10;
   localparam int YW = 10;
   localparam int AW = 19;

   logic pclk = 1'b0;
   logic reset_n;
   always #5 pclk = ~pclk;

   ov7670_capture_if #(.XW(XW), .YW(YW), .AW(AW)) bus ();

   ov7670_capture #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .AW(AW)) dut (
      .pclk    (pclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [15:0] v; int x; int y; int a; } wr_t;
   typedef struct { bit err; int cnt; } fr_t;

   wr_t        sb[$];
   fr_t        fq[$];
   logic [7:0] lb[$];
   int         strobes  = 0;
   int         dones    = 0;
   int         last_mem = 0;
   int         m_mode, m_line, m_frames = 0;
   bit         m_err;
   bit         lat_chk  = 0;
   int         lat_idx  = 0;
   logic [15:0] lat_v;

   always @(negedge pclk) begin : mon
      wr_t e;
      fr_t f;
      if (reset_n) begin
         if (bus.is_val) begin
            strobes++;
            last_mem = int'(bus.mem_addr);
            check("strobe_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("value",    bus.value,    e.v);
               check("x_addr",   bus.x_addr,   e.x);
               check("y_addr",   bus.y_addr,   e.y);
               check("mem_addr", bus.mem_addr, e.a);
            end
         end
         if (bus.frame_done) begin
            dones++;
            check("done_expected", 64'(fq.size() != 0), 64'd1);
            if (fq.size() != 0) begin
               f = fq.pop_front();
               check("frame_err", bus.frame_err, f.err);
               check("frame_cnt", bus.frame_cnt, f.cnt);
            end
         end else begin
            check("frame_err_idle", bus.frame_err, 0);
         end
      end
   end

   // Reference: a camera line of n bytes yields n/bpp pixels; only the first OUT_W of
   // the first IMG_H lines are written, anything else marks the frame bad.
   task automatic model_line();
      int n, ow, bpp, np, v;
      n   = lb.size();
      ow  = (m_mode == 2) ? W / 2 : W;
      bpp = (m_mode == 2) ? 4 : 2;
      np  = n / bpp;
      for (int i = 0; i < np; i++) begin
         if (m_mode == 0)      v = lb[2*i+1];
         else if (m_mode == 1) v = {lb[2*i], lb[2*i+1]};
         else                  v = (int'(lb[4*i+1]) + int'(lb[4*i+3]) + 1) / 2;
         if (m_line < H && i < ow)
            sb.push_back('{v: 16'(v), x: i, y: m_line, a: m_line * ow + i});
      end
      if (m_line >= H || np != ow || (n % bpp) != 0) m_err = 1;
      m_line++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pclk); #1;
         bus.href = 1'b0;
         bus.data = 8'($urandom);
      end
   endtask

   task automatic drive_byte(input logic [7:0] b);
      @(posedge pclk); #1;
      bus.href = 1'b1;
      bus.data = b;
   endtask

   task automatic fill_rand(input int n);
      lb.delete();
      repeat (n) lb.push_back(8'($urandom));
   endtask

   task automatic fill_ramp(input int n);
      lb.delete();
      for (int i = 0; i < n; i++) lb.push_back((i % 2) ? 8'(i / 2) : 8'($urandom));
   endtask

   task automatic send_line(input bit on, input int gap);
      if (on) model_line();
      for (int i = 0; i < lb.size(); i++) begin
         drive_byte(lb[i]);
         if (lat_chk && i == lat_idx + 1) begin
            @(negedge pclk);
            check("lat_is_val", bus.is_val, 1);
            check("lat_value",  bus.value,  lat_v);
         end
      end
      lat_chk = 0;
      idle(gap);
   endtask

   task automatic start_frame(input int md);
      @(posedge pclk); #1;
      bus.mode  = 2'(md);
      bus.vsync = 1'b1;
      bus.href  = 1'b0;
      idle(3);
      @(posedge pclk); #1;
      bus.vsync = 1'b0;
      m_mode = (md == 3) ? 0 : md;
      m_line = 0;
      m_err  = 0;
      idle(2);
   endtask

   task automatic end_frame(input bit hot);
      int exp_d;
      exp_d = dones + 1;
      @(posedge pclk); #1;
      bus.vsync = 1'b1;
      bus.href  = hot;
      bus.data  = 8'($urandom);
      m_frames++;
      fq.push_back('{err: (m_err || m_line != H), cnt: m_frames % 256});
      idle(4);
      check("frame_done_seen", dones, exp_d);
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, {bus.value, bus.mem_addr, bus.x_addr, bus.y_addr}, 0);
      check({tag, "_flags"}, {bus.is_val, bus.frame_done, bus.frame_err, bus.frame_cnt}, 0);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int s0, nl, len, md;
      bus.vsync = 1'b0;
      bus.href  = 1'b0;
      bus.data  = 8'h00;
      bus.mode  = 2'd0;
      reset_n   = 1'b1;
      #1 reset_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(posedge pclk);
      #1 reset_n = 1'b1;

      // href lines before any vsync high must be ignored
      idle(2);
      repeat (2) begin fill_rand(2*W); send_line(0, 3); end
      check("sync_no_strobe", strobes, 0);

      // full Y-only frame with a ramp
      start_frame(0);
      for (int l = 0; l < H; l++) begin fill_ramp(2*W); send_line(1, 3); end
      end_frame(0);
      check("full_strobes", strobes, W*H);
      check("last_mem", last_mem, W*H - 1);

      // RGB565 latency and value
      start_frame(1);
      fill_rand(2*W); lb[0] = 8'hF8; lb[1] = 8'h1F;
      lat_chk = 1; lat_idx = 1; lat_v = 16'hF81F;
      send_line(1, 3);
      for (int l = 1; l < H; l++) begin fill_rand(2*W); send_line(1, 3); end
      end_frame(0);

      // Y average mode
      start_frame(2);
      fill_rand(2*W); lb[1] = 8'd10; lb[3] = 8'd13;
      lat_chk = 1; lat_idx = 3; lat_v = 16'd12;
      s0 = strobes;
      send_line(1, 3);
      check("yavg_strobes_line", strobes - s0, W/2);
      for (int l = 1; l < H; l++) begin fill_rand(2*W); send_line(1, 3); end
      end_frame(0);

      // short line followed by full lines
      start_frame(0);
      fill_rand(2*(W-4)); send_line(1, 3);
      for (int l = 1; l < H; l++) begin fill_rand(2*W); send_line(1, 3); end
      end_frame(0);

      // mode change mid-frame takes effect next frame only
      start_frame(0);
      fill_rand(2*W); send_line(1, 3);
      bus.mode = 2'd1;
      for (int l = 1; l < H; l++) begin fill_rand(2*W); send_line(1, 3); end
      end_frame(0);
      start_frame(1);
      for (int l = 0; l < H; l++) begin fill_rand(2*W); send_line(1, 3); end
      end_frame(0);

      // reserved mode, overlong, odd trailing byte, extra line, hot end
      start_frame(3);
      fill_rand(2*W + 4); send_line(1, 2);
      fill_rand(2*W + 1); send_line(1, 2);
      for (int l = 2; l < H + 1; l++) begin fill_rand(2*W); send_line(1, 2); end
      fill_rand(2*W); send_line(1, 0);
      end_frame(1);

      // clean frame closed by vsync rising while href is still high
      start_frame(1);
      for (int l = 0; l < H - 1; l++) begin fill_rand(2*W); send_line(1, 1); end
      fill_rand(2*W); send_line(1, 0);
      end_frame(1);

      // randomised frames
      repeat (6) begin
         md = $urandom_range(0, 3);
         start_frame(md);
         nl = ($urandom_range(0, 3) == 0) ? H - 1 + $urandom_range(0, 2) : H;
         for (int l = 0; l < nl; l++) begin
            len = 2*W;
            if ($urandom_range(0, 5) == 0) len = 2*W + $urandom_range(0, 6) - 3;
            fill_rand(len);
            if ($urandom_range(0, 4) == 0) bus.mode = 2'($urandom_range(0, 3));
            send_line(1, (l == nl - 1) ? $urandom_range(0, 2) : $urandom_range(1, 4));
         end
         end_frame($urandom_range(0, 1));
      end

      // reset mid-frame discards the partial frame
      start_frame(0);
      for (int l = 0; l < 3; l++) begin fill_rand(2*W); send_line(1, 3); end
      @(posedge pclk); #1;
      reset_n = 1'b0;
      #1 check_reset_outputs("midreset");
      sb.delete();
      fq.delete();
      m_frames = 0;
      @(posedge pclk); #1;
      reset_n = 1'b1;
      idle(3);
      start_frame(0);
      for (int l = 0; l < H; l++) begin fill_rand(2*W); send_line(1, 3); end
      end_frame(0);
      check("post_reset_cnt", bus.frame_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
